// File: rtl/rx_ctrl_dec_if.sv
// Port bundle for rx_ctrl_dec: serial line and local ID in, decoded command fields and strobes out.
interface rx_ctrl_dec_if;
   logic        rx_ctrl;
   logic [7:0]  my_dev_id;
   logic [7:0]  dev_id;
   logic [7:0]  mod_id;
   logic [7:0]  cmd_addr;
   logic [7:0]  cmd_data;
   logic        cmd_vld;
   logic        frm_err;
   logic [15:0] err_cnt;

   modport master (
      input  rx_ctrl, my_dev_id,
      output dev_id, mod_id, cmd_addr, cmd_data, cmd_vld, frm_err, err_cnt
   );

   modport slave (
      output rx_ctrl, my_dev_id,
      input  dev_id, mod_id, cmd_addr, cmd_data, cmd_vld, frm_err, err_cnt
   );
endinterface

// File: rtl/rx_ctrl_dec.sv
// Control-line receiver: UART byte deserialiser, 6-byte frame check, device-ID filter, command strobe.
// Optional macro RX_CTRL_ERRCNT_EN builds a saturating rejected-frame counter on err_cnt.
module rx_ctrl_dec #(
   parameter int unsigned CLK_DIV      = 100,
   parameter logic [7:0]  HDR_BYTE     = 8'hA5,
   parameter int unsigned TIMEOUT_BITS = 20
) (
   input logic           clk_sys,
   input logic           rst,
   rx_ctrl_dec_if.master bus
);
   localparam int unsigned      CNT_W     = $clog2(CLK_DIV);
   localparam int unsigned      TO_LIMIT  = TIMEOUT_BITS * CLK_DIV;
   localparam int unsigned      TO_W      = $clog2(TO_LIMIT + 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_DIV / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TO_LIMIT - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} bit_st_e;
   typedef enum logic [2:0] {
      F_HDR = 3'd0, F_DEV = 3'd1, F_MOD = 3'd2, F_ADDR = 3'd3, F_DATA = 3'd4, F_CSUM = 3'd5
   } frm_st_e;

   function automatic logic [7:0] frame_csum(input logic [7:0] d, input logic [7:0] m,
                                             input logic [7:0] a, input logic [7:0] x);
      frame_csum = d ^ m ^ a ^ x;
   endfunction

   logic             sync1_q, sync1_d, sync2_q, sync2_d, rxs_prev_q, rxs_prev_d;
   bit_st_e          bit_st_q, bit_st_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [7:0]       shift_q, shift_d;
   logic             byte_rdy_q, byte_rdy_d, byte_err_q, byte_err_d;
   frm_st_e          frm_st_q, frm_st_d;
   logic [TO_W-1:0]  tmo_q, tmo_d;
   logic [7:0]       dev_sh_q, dev_sh_d, mod_sh_q, mod_sh_d, addr_sh_q, addr_sh_d, data_sh_q, data_sh_d;
   logic [7:0]       dev_id_q, dev_id_d, mod_id_q, mod_id_d, cmd_addr_q, cmd_addr_d, cmd_data_q, cmd_data_d;
   logic             cmd_vld_q, cmd_vld_d, frm_err_q, frm_err_d;
   logic             rxs_s, fall_s, tmo_run_s, id_ok_s;

   // Synchroniser, edge detect and bit-level deserialiser
   always_comb begin
      sync1_d    = bus.rx_ctrl;
      sync2_d    = sync1_q;
      rxs_prev_d = sync2_q;
      rxs_s      = sync2_q;
      fall_s     = rxs_prev_q & ~rxs_s;
      bit_st_d   = bit_st_q;
      cnt_d      = cnt_q;
      bit_idx_d  = bit_idx_q;
      shift_d    = shift_q;
      byte_rdy_d = 1'b0;
      byte_err_d = 1'b0;
      case (bit_st_q)
         IDLE: begin
            if (fall_s) begin
               bit_st_d = START;
               cnt_d    = {CNT_W{1'b0}};
            end else begin
               cnt_d = cnt_q;
            end
         end
         START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d     = {CNT_W{1'b0}};
               bit_idx_d = 3'd0;
               bit_st_d  = rxs_s ? IDLE : DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d     = {CNT_W{1'b0}};
               shift_d   = {rxs_s, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               bit_st_d  = (bit_idx_q == 3'd7) ? STOP : DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d      = {CNT_W{1'b0}};
               byte_rdy_d = rxs_s;
               byte_err_d = ~rxs_s;
               bit_st_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: bit_st_d = IDLE;
      endcase
   end

   // Frame assembly, checksum/ID filter and inter-byte timeout
   always_comb begin
      frm_st_d   = frm_st_q;
      dev_sh_d   = dev_sh_q;
      mod_sh_d   = mod_sh_q;
      addr_sh_d  = addr_sh_q;
      data_sh_d  = data_sh_q;
      dev_id_d   = dev_id_q;
      mod_id_d   = mod_id_q;
      cmd_addr_d = cmd_addr_q;
      cmd_data_d = cmd_data_q;
      cmd_vld_d  = 1'b0;
      frm_err_d  = 1'b0;
      tmo_run_s  = (frm_st_q != F_HDR) && (bit_st_q == IDLE);
      id_ok_s    = (dev_sh_q == bus.my_dev_id) || (dev_sh_q == 8'hFF);
      if (fall_s || (frm_st_q == F_HDR)) begin
         tmo_d = {TO_W{1'b0}};
      end else if (tmo_run_s) begin
         tmo_d = tmo_q + TO_W'(1);
      end else begin
         tmo_d = tmo_q;
      end
      if (byte_err_q && (frm_st_q != F_HDR)) begin
         frm_err_d = 1'b1;
         frm_st_d  = F_HDR;
      end else if (tmo_run_s && (tmo_q == TO_LAST)) begin
         frm_err_d = 1'b1;
         frm_st_d  = F_HDR;
      end else if (byte_rdy_q) begin
         case (frm_st_q)
            F_HDR:  frm_st_d = (shift_q == HDR_BYTE) ? F_DEV : F_HDR;
            F_DEV:  begin dev_sh_d  = shift_q; frm_st_d = F_MOD;  end
            F_MOD:  begin mod_sh_d  = shift_q; frm_st_d = F_ADDR; end
            F_ADDR: begin addr_sh_d = shift_q; frm_st_d = F_DATA; end
            F_DATA: begin data_sh_d = shift_q; frm_st_d = F_CSUM; end
            F_CSUM: begin
               frm_st_d = F_HDR;
               if (shift_q != frame_csum(dev_sh_q, mod_sh_q, addr_sh_q, data_sh_q)) begin
                  frm_err_d = 1'b1;
               end else if (id_ok_s) begin
                  dev_id_d   = dev_sh_q;
                  mod_id_d   = mod_sh_q;
                  cmd_addr_d = addr_sh_q;
                  cmd_data_d = data_sh_q;
                  cmd_vld_d  = 1'b1;
               end else begin
                  cmd_vld_d = 1'b0;
               end
            end
            default: frm_st_d = F_HDR;
         endcase
      end else begin
         frm_st_d = frm_st_q;
      end
   end

   // State registers
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rxs_prev_q <= 1'b1;
         bit_st_q   <= IDLE;
         cnt_q      <= {CNT_W{1'b0}};
         bit_idx_q  <= 3'd0;
         shift_q    <= 8'h00;
         byte_rdy_q <= 1'b0;
         byte_err_q <= 1'b0;
         frm_st_q   <= F_HDR;
         tmo_q      <= {TO_W{1'b0}};
         dev_sh_q   <= 8'h00;
         mod_sh_q   <= 8'h00;
         addr_sh_q  <= 8'h00;
         data_sh_q  <= 8'h00;
         dev_id_q   <= 8'h00;
         mod_id_q   <= 8'h00;
         cmd_addr_q <= 8'h00;
         cmd_data_q <= 8'h00;
         cmd_vld_q  <= 1'b0;
         frm_err_q  <= 1'b0;
      end else begin
         sync1_q    <= sync1_d;
         sync2_q    <= sync2_d;
         rxs_prev_q <= rxs_prev_d;
         bit_st_q   <= bit_st_d;
         cnt_q      <= cnt_d;
         bit_idx_q  <= bit_idx_d;
         shift_q    <= shift_d;
         byte_rdy_q <= byte_rdy_d;
         byte_err_q <= byte_err_d;
         frm_st_q   <= frm_st_d;
         tmo_q      <= tmo_d;
         dev_sh_q   <= dev_sh_d;
         mod_sh_q   <= mod_sh_d;
         addr_sh_q  <= addr_sh_d;
         data_sh_q  <= data_sh_d;
         dev_id_q   <= dev_id_d;
         mod_id_q   <= mod_id_d;
         cmd_addr_q <= cmd_addr_d;
         cmd_data_q <= cmd_data_d;
         cmd_vld_q  <= cmd_vld_d;
         frm_err_q  <= frm_err_d;
      end
   end

   assign bus.dev_id   = dev_id_q;
   assign bus.mod_id   = mod_id_q;
   assign bus.cmd_addr = cmd_addr_q;
   assign bus.cmd_data = cmd_data_q;
   assign bus.cmd_vld  = cmd_vld_q;
   assign bus.frm_err  = frm_err_q;

`ifdef RX_CTRL_ERRCNT_EN
   logic [15:0] err_cnt_q, err_cnt_d;

   // Saturating rejected-frame count, updated on the same edge as frm_err
   always_comb begin
      if (frm_err_d && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_d = err_cnt_q + 16'd1;
      end else begin
         err_cnt_d = err_cnt_q;
      end
   end

   // Counter register
   always_ff @(posedge clk_sys) begin
      if (rst) begin
         err_cnt_q <= 16'h0000;
      end else begin
         err_cnt_q <= err_cnt_d;
      end
   end

   assign bus.err_cnt = err_cnt_q;
`else
   assign bus.err_cnt = 16'h0000;
`endif
endmodule
